ibex_bus_responder: RTL and testbench
=====================================

# ibex_bus_responder

Synthesizable memory-side responder for the Ibex instruction/data bus protocol (req/gnt/rvalid). It instantiates a word-addressed memory and services requests with configurable grant delay and response latency. Up to a bounded number of requests can be outstanding, and responses return in order. It sits opposite the core's `instr_*` or `data_*` ports in simulation tops and standalone test harnesses, and can also back small on-chip RAMs.

## Interface
Parameters:
- `MemWords`, 1024 — memory depth in 32-bit words; power of two, ≥ 4.
- `MaxOutstanding`, 2 — granted-but-not-responded requests; range 1..4.
- `GntDelay`, 0 — cycles `req_i` must be held before `gnt_o`; range 0..15.
- `RvalidLatency`, 1 — cycles from grant to `rvalid_o`; range 1..15.
- `ErrAddrBase`, 32'hFFFF_F000 — base of the error-injection window.
- `ErrAddrMask`, 32'hFFFF_F000 — error window match mask.

Ports:
- `clk_i` in 1 — clock.
- `rst_ni` in 1 — reset, asynchronous, active-low.
- `req_i` in 1 — request valid.
- `gnt_o` out 1 — request accepted this cycle.
- `we_i` in 1 — 1 = write, 0 = read.
- `be_i` in 4 — byte enables.
- `addr_i` in 32 — byte address; bits [1:0] ignored.
- `wdata_i` in 32 — write data.
- `rvalid_o` out 1 — response valid.
- `rdata_o` out 32 — read data; 0 for writes and errors.
- `err_o` out 1 — response is an error; qualified by `rvalid_o`.

## Operation
- **Word index.** `idx = addr_i[$clog2(MemWords)+1:2]`.
- **Out-of-range.** An access is out of range if `addr_i[31:$clog2(MemWords)+2] != 0`.
- **Error condition.** An access is an error if it is out of range or `(addr_i & ErrAddrMask) == (ErrAddrBase & ErrAddrMask)`.
- **Grant counter.**
  - `wait_cnt` increments each cycle `req_i=1 && gnt_o=0`.
  - It clears when `req_i=0` or `gnt_o=1`.
  - It saturates at `GntDelay`.
- **Grant.** `gnt_o = req_i && (wait_cnt == GntDelay) && (outstanding < MaxOutstanding || rvalid_o)`. This is combinational; at most one grant per cycle.
- **On grant (clock edge).**
  - Write, no error: memory bytes with `be_i[k]=1` take `wdata_i[8k+7:8k]`.
  - Read, no error: data is sampled from memory at this edge.
  - Error: no write; response data is 0.
  - In all cases, push `{rdata, err, age=0}` into a `MaxOutstanding`-deep in-order response FIFO.
- **Age.** Every FIFO entry's age increments each cycle, saturating at `RvalidLatency`.
- **Response.** `rvalid_o = FIFO not empty && head.age == RvalidLatency`. `rdata_o`/`err_o` come from the head entry, and the head pops in that cycle.
- **Outstanding count.** `outstanding` counts FIFO occupancy.
  - A push and a pop in the same cycle leave it unchanged.
  - It never exceeds `MaxOutstanding`; the grant term allows a push to full only when a pop occurs.
- **Memory.** Contents are not reset; they hold X until written.

## Timing
- **Reset values.** `gnt_o=0` (since `req_i` is sampled combinationally, `gnt_o=0` whenever `rst_ni=0`), `rvalid_o=0`, `rdata_o=0`, `err_o=0`, FIFO empty, `wait_cnt=0`.
- **Grant timing.** With `GntDelay=0`, `gnt_o` is in the same cycle as the first `req_i` cycle. With `GntDelay=N`, grant is in the (N+1)-th consecutive `req_i` cycle.
- **Response timing.** `rvalid_o` follows exactly `RvalidLatency` cycles after the grant cycle when the FIFO is ahead-clear. Later responses are never earlier than one cycle after the previous `rvalid_o`.
- **Read-after-write.** A read granted in the cycle after a write to the same word returns the new data.
- **Full FIFO.** No grant; `req_i` stays pending and `wait_cnt` holds at `GntDelay`.
- **Full + pop same cycle.** Grant is allowed.
- **Reset mid-operation.** Pending responses are dropped and no `rvalid_o` is emitted for them; writes already granted remain in memory.

## Configuration
- **`IBEX_BUS_RESPONDER_ASSERT_EN` defined.** Concurrent assertions are compiled in:
  - `addr_i`/`we_i`/`be_i`/`wdata_i` are stable while `req_i && !gnt_o`.
  - `req_i` is not deasserted before `gnt_o`.
  - `be_i != 0` on a granted write.
  - `rvalid_o` only with a non-empty FIFO.
  - A violation reports via `$error` with the cycle time.
- **Undefined.** No assertion logic; RTL behaviour is identical.

## Test plan
- **Single read/write.** `GntDelay=0`, `RvalidLatency=1`: write `0xDEADBEEF` to `0x10` with `be=4'hF`, then read `0x10`. Expect grant on the request cycle, `rvalid` the next cycle, and `rdata_o=0xDEADBEEF` with `err_o=0`.
- **Grant delay and byte enables.** `GntDelay=3`: write `be=4'b0010` with data `0x0000AB00` over `0x11223344`. Expect `gnt_o` in the 4th `req_i` cycle and a subsequent read returning `0x1122AB44`.
- **Backpressure.** `MaxOutstanding=2`, `RvalidLatency=4`, three back-to-back reads. Expect grants in cycles 0 and 1, the third grant in cycle 4 (same cycle as the first `rvalid`), and in-order data.
- **Error injection.**
  - Read `0xFFFF_F004`: `rvalid_o=1`, `err_o=1`, `rdata_o=0`.
  - Write `0x0001_0000` (`MemWords=1024`): `err_o=1`, memory unchanged.
- **Reset mid-operation.** Assert `rst_ni=0` one cycle after two grants. Expect `rvalid_o=0` immediately and after reset release; a new read returns the previously written data.
- **Assertion build.** With `IBEX_BUS_RESPONDER_ASSERT_EN`, change `addr_i` while `req_i=1`, `gnt_o=0` (`GntDelay=2`). Expect a stability assertion failure.

Source files
------------

// File: rtl/ibex_bus_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus: word memory, grant delay,
// fixed response latency, in-order response FIFO. Define IBEX_BUS_RESPONDER_ASSERT_EN
// to compile in protocol assertions.
module ibex_bus_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RvalidLatency  = 1,
  parameter logic [31:0] ErrAddrBase    = 32'hFFFF_F000,
  parameter logic [31:0] ErrAddrMask    = 32'hFFFF_F000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AddrW    = $clog2(MemWords);
  localparam logic [3:0]  GntDelayC = 4'(GntDelay);
  localparam logic [3:0]  LatC      = 4'(RvalidLatency);
  localparam logic [2:0]  MaxOutC   = 3'(MaxOutstanding);
  localparam logic [1:0]  LastPtr   = 2'(MaxOutstanding - 1);

  logic [31:0]      mem [MemWords];
  logic [AddrW-1:0] idx;
  logic             out_of_range;
  logic             in_err_win;
  logic             acc_err;
  logic [31:0]      rd_word;
  logic             unused_addr_lsb;

  // Response FIFO is sized for the largest legal MaxOutstanding; pointers wrap early.
  logic [31:0] rdata_q [4];
  logic [31:0] rdata_d [4];
  logic        err_q   [4];
  logic        err_d   [4];
  logic [3:0]  age_q   [4];
  logic [3:0]  age_d   [4];
  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        push;
  logic        pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LastPtr) ? 2'd0 : p + 2'd1;
  endfunction

  assign idx             = addr_i[AddrW+1:2];
  assign out_of_range    = |addr_i[31:AddrW+2];
  assign in_err_win      = (addr_i & ErrAddrMask) == (ErrAddrBase & ErrAddrMask);
  assign acc_err         = out_of_range | in_err_win;
  assign rd_word         = mem[idx];
  assign unused_addr_lsb = ^addr_i[1:0];

  assign rvalid_o = (count_q != 3'd0) && (age_q[head_q] == LatC);
  // A pop in the same cycle frees a slot, so a full FIFO may still accept a grant.
  assign gnt_o    = rst_ni && req_i && (wait_cnt_q == GntDelayC) &&
                    ((count_q < MaxOutC) || rvalid_o);
  assign rdata_o  = rvalid_o ? rdata_q[head_q] : 32'h0;
  assign err_o    = rvalid_o && err_q[head_q];

  assign push = gnt_o;
  assign pop  = rvalid_o;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req_i || gnt_o) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != GntDelayC) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    for (int i = 0; i < 4; i++) begin
      age_d[i] = (age_q[i] < LatC) ? age_q[i] + 4'd1 : age_q[i];
    end

    if (pop) begin
      head_d = next_ptr(head_q);
    end
    // The grant cycle itself counts as the first cycle of age.
    if (push) begin
      rdata_d[tail_q] = (we_i || acc_err) ? 32'h0 : rd_word;
      err_d[tail_q]   = acc_err;
      age_d[tail_q]   = 4'd1;
      tail_d          = next_ptr(tail_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      count_q    <= 3'd0;
      wait_cnt_q <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        rdata_q[i] <= 32'h0;
        err_q[i]   <= 1'b0;
        age_q[i]   <= 4'd0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      age_q      <= age_d;
    end
  end

  // Memory is deliberately not reset so granted writes survive a reset.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

`ifdef IBEX_BUS_RESPONDER_ASSERT_EN
  property p_req_stable;
    @(posedge clk_i) disable iff (!rst_ni)
      (req_i && !gnt_o) |=> ($stable(addr_i) && $stable(we_i) && $stable(be_i) &&
                             $stable(wdata_i));
  endproperty

  property p_req_held;
    @(posedge clk_i) disable iff (!rst_ni) (req_i && !gnt_o) |=> req_i;
  endproperty

  property p_be_nonzero;
    @(posedge clk_i) disable iff (!rst_ni) (gnt_o && we_i) |-> (be_i != 4'h0);
  endproperty

  property p_rvalid_nonempty;
    @(posedge clk_i) disable iff (!rst_ni) rvalid_o |-> (count_q != 3'd0);
  endproperty

  a_req_stable: assert property (p_req_stable)
    else $error("ibex_bus_responder: request changed while waiting for grant at %0t", $time);
  a_req_held: assert property (p_req_held)
    else $error("ibex_bus_responder: req_i dropped before gnt_o at %0t", $time);
  a_be_nonzero: assert property (p_be_nonzero)
    else $error("ibex_bus_responder: granted write with be_i == 0 at %0t", $time);
  a_rvalid_nonempty: assert property (p_rvalid_nonempty)
    else $error("ibex_bus_responder: rvalid_o with empty response FIFO at %0t", $time);
`endif

endmodule

// File: tb/tb_ibex_bus_responder.sv
// Directed bench for ibex_bus_responder: three instances cover the zero-delay,
// grant-delay and backpressure configurations.
module tb_ibex_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        req    [3];
  logic        gnt    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ibex_bus_responder #(
    .MemWords(1024), .MaxOutstanding(2), .GntDelay(0), .RvalidLatency(1)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]),
    .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0])
  );

  ibex_bus_responder #(
    .MemWords(1024), .MaxOutstanding(2), .GntDelay(3), .RvalidLatency(1)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]),
    .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1])
  );

  ibex_bus_responder #(
    .MemWords(1024), .MaxOutstanding(2), .GntDelay(0), .RvalidLatency(4)
  ) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]),
    .be_i(be[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the request until granted. Returns the number of
  // non-granted request cycles, or -1 on timeout. Leaves req low at posedge+1.
  task automatic do_req(input int i, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, output int ncyc);
    ncyc     = -1;
    req[i]   = 1'b1;
    we[i]    = w;
    be[i]    = b;
    addr[i]  = a;
    wdata[i] = d;
    for (int c = 0; c < 40; c++) begin
      #4;
      if (gnt[i]) begin
        ncyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  // Called at posedge+1 of the cycle after the grant; lat counts cycles from the grant.
  task automatic wait_rsp(input int i, output int lat, output logic [31:0] d, output logic e);
    lat = -1;
    d   = 32'hx;
    e   = 1'bx;
    for (int c = 1; c < 40; c++) begin
      #4;
      if (rvalid[i]) begin
        lat = c;
        d   = rdata[i];
        e   = err[i];
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input string tag, input int i, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d, input int exp_wait,
                      input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
    int          ncyc;
    int          lat;
    logic [31:0] rd;
    logic        e;
    do_req(i, w, b, a, d, ncyc);
    check_eq({tag, "_gnt_wait"}, ncyc, exp_wait);
    wait_rsp(i, lat, rd, e);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_rdata"}, rd, exp_data);
    check_eq({tag, "_err"}, {31'h0, e}, {31'h0, exp_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int saw;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    req[0] = 1'b1;
    #4;
    check_eq("rst_gnt", {31'h0, gnt[0]}, 32'h0);
    check_eq("rst_rvalid", {31'h0, rvalid[0]}, 32'h0);
    check_eq("rst_rdata", rdata[0], 32'h0);
    check_eq("rst_err", {31'h0, err[0]}, 32'h0);
    req[0] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single write then read, zero grant delay, latency 1.
    xact("wr10", 0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0);
    xact("rd10", 0, 1'b0, 4'hF, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0);

    // Back-to-back write then read of the same word.
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h44; wdata[0] = 32'hCAFE_F00D;
    #4;
    check_eq("raw_wr_gnt", {31'h0, gnt[0]}, 32'h1);
    step();
    we[0] = 1'b0;
    #4;
    check_eq("raw_rd_gnt", {31'h0, gnt[0]}, 32'h1);
    check_eq("raw_wr_rvalid", {31'h0, rvalid[0]}, 32'h1);
    check_eq("raw_wr_rdata", rdata[0], 32'h0);
    step();
    req[0] = 1'b0;
    #4;
    check_eq("raw_rd_rvalid", {31'h0, rvalid[0]}, 32'h1);
    check_eq("raw_rd_rdata", rdata[0], 32'hCAFE_F00D);
    step();
    #4;
    check_eq("raw_idle_rvalid", {31'h0, rvalid[0]}, 32'h0);
    step();

    // Grant delay 3 and byte enables.
    xact("gd_wr", 1, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 3, 1, 32'h0, 1'b0);
    xact("gd_be", 1, 1'b1, 4'b0010, 32'h20, 32'h0000_AB00, 3, 1, 32'h0, 1'b0);
    xact("gd_rd", 1, 1'b0, 4'hF, 32'h20, 32'h0, 3, 1, 32'h1122_AB44, 1'b0);

    // Error window and out-of-range write that must not alias onto word 0.
    xact("w0", 0, 1'b1, 4'hF, 32'h0, 32'hA5A5_A5A5, 0, 1, 32'h0, 1'b0);
    xact("err_rd", 0, 1'b0, 4'hF, 32'hFFFF_F004, 32'h0, 0, 1, 32'h0, 1'b1);
    xact("oor_wr", 0, 1'b1, 4'hF, 32'h0001_0000, 32'h1234_5678, 0, 1, 32'h0, 1'b1);
    xact("w0_rd", 0, 1'b0, 4'hF, 32'h0, 32'h0, 0, 1, 32'hA5A5_A5A5, 1'b0);

    // Backpressure: two outstanding, latency 4.
    xact("bp_w0", 2, 1'b1, 4'hF, 32'h0, 32'h1111_0001, 0, 4, 32'h0, 1'b0);
    xact("bp_w1", 2, 1'b1, 4'hF, 32'h4, 32'h2222_0002, 0, 4, 32'h0, 1'b0);
    xact("bp_w2", 2, 1'b1, 4'hF, 32'h8, 32'h3333_0003, 0, 4, 32'h0, 1'b0);
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h0;
    #4;
    check_eq("bp_c0_gnt", {31'h0, gnt[2]}, 32'h1);
    step();
    addr[2] = 32'h4;
    #4;
    check_eq("bp_c1_gnt", {31'h0, gnt[2]}, 32'h1);
    step();
    addr[2] = 32'h8;
    #4;
    check_eq("bp_c2_gnt", {31'h0, gnt[2]}, 32'h0);
    step();
    #4;
    check_eq("bp_c3_gnt", {31'h0, gnt[2]}, 32'h0);
    check_eq("bp_c3_rvalid", {31'h0, rvalid[2]}, 32'h0);
    step();
    #4;
    check_eq("bp_c4_gnt", {31'h0, gnt[2]}, 32'h1);
    check_eq("bp_c4_rvalid", {31'h0, rvalid[2]}, 32'h1);
    check_eq("bp_c4_rdata", rdata[2], 32'h1111_0001);
    step();
    req[2] = 1'b0;
    #4;
    check_eq("bp_c5_rvalid", {31'h0, rvalid[2]}, 32'h1);
    check_eq("bp_c5_rdata", rdata[2], 32'h2222_0002);
    step();
    #4;
    check_eq("bp_c6_rvalid", {31'h0, rvalid[2]}, 32'h0);
    step();
    #4;
    check_eq("bp_c7_rvalid", {31'h0, rvalid[2]}, 32'h0);
    step();
    #4;
    check_eq("bp_c8_rvalid", {31'h0, rvalid[2]}, 32'h1);
    check_eq("bp_c8_rdata", rdata[2], 32'h3333_0003);
    step();

    // Reset with two responses pending.
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0;
    #4;
    check_eq("mr_c0_gnt", {31'h0, gnt[2]}, 32'h1);
    step();
    addr[2] = 32'h4;
    #4;
    check_eq("mr_c1_gnt", {31'h0, gnt[2]}, 32'h1);
    step();
    req[2] = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq("mr_rst_rvalid", {31'h0, rvalid[2]}, 32'h0);
    check_eq("mr_rst_rdata", rdata[2], 32'h0);
    step();
    step();
    rst_n = 1'b1;
    saw = 0;
    for (int c = 0; c < 8; c++) begin
      #4;
      if (rvalid[2]) saw = 1;
      step();
    end
    check_eq("mr_no_stale_rvalid", saw, 0);
    xact("mr_rd8", 2, 1'b0, 4'hF, 32'h8, 32'h0, 0, 4, 32'h3333_0003, 1'b0);
    xact("mr_rd10", 0, 1'b0, 4'hF, 32'h10, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
